// File: rtl/rr_arbiter8_pkg.sv
// Shared types and widths for the 8-way round-robin arbiter.
//   state_e : arbiter FSM encodings
//   NUM_REQ : number of requesters
//   IDX_W   : width of a requester index
//   CNT_W   : width of the saturating hold counter
package rr_arbiter8_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between requesting units and the arbiter.
//   req         : per-requester request lines (level)
//   done        : release pulse from the current owner
//   grant       : one-hot grant, zero while nobody owns the resource
//   grant_idx   : current or most recent owner (shared-resource mux select)
//   grant_valid : resource is owned
//   timeout     : one-cycle pulse on a forced release
interface rr_arbiter8_if;
  import rr_arbiter8_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               timeout;

  // Requester side
  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, timeout
  );

  // Arbiter side
  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, timeout
  );

endinterface

// File: rtl/decoder3b8.sv
// 3-to-8 one-hot decoder.
//   in_i  : binary index
//   out_o : one-hot vector with bit in_i set
module decoder3b8 (
  input  logic [2:0] in_i,
  output logic [7:0] out_o
);

  assign out_o = 8'h01 << in_i;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter sharing one resource between 8 requesters.
// Grant is registered, held until done / request drop / MAX_HOLD expiry,
// followed by exactly one zero-grant turnaround cycle.
//   CLK, RST_N : clock and synchronous active-low reset
//   bus        : request/grant bundle (slave side)
//   MAX_HOLD   : max cycles per grant, 0..255, 0 disables the timeout
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  rr_arbiter8_if.slave bus
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               grant_valid_q, grant_valid_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               timeout_q, timeout_d;
  logic [IDX_W-1:0]   sel_idx_c;
  logic               hold_hit_c;
  logic [NUM_REQ-1:0] dec_out;

  // First requester at or after p, wrapping modulo NUM_REQ. The scan runs
  // from the farthest offset down so the nearest hit is written last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] k;
    rr_pick = p;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = p + IDX_W'(i);
      if (r[k]) rr_pick = k;
    end
  endfunction

  assign sel_idx_c  = rr_pick(bus.req, ptr_q);
  assign hold_hit_c = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      hold_cnt_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      hold_cnt_q    <= hold_cnt_d;
      timeout_q     <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    hold_cnt_d    = hold_cnt_q;
    timeout_d     = 1'b0;

    case (state_q)
      IDLE, RELEASE: begin
        if (|bus.req) begin
          grant_idx_d   = sel_idx_c;
          grant_valid_d = 1'b1;
          hold_cnt_d    = '0;
          state_d       = BUSY;
        end else begin
          grant_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      BUSY: begin
        hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + CNT_W'(1);
        if (bus.done || !bus.req[grant_idx_q] || hold_hit_c) begin
          grant_valid_d = 1'b0;
          ptr_d         = grant_idx_q + IDX_W'(1);
          state_d       = RELEASE;
          // Only a pure timeout pulses; done or request drop take priority.
          timeout_d     = !bus.done && bus.req[grant_idx_q];
        end
      end
      default: begin
        grant_valid_d = 1'b0;
        state_d       = IDLE;
      end
    endcase
  end

  decoder3b8 u_dec (
    .in_i  (grant_idx_q),
    .out_o (dec_out)
  );

  assign bus.grant       = dec_out & {NUM_REQ{grant_valid_q}};
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

endmodule
